sha256_round_ctrl: RTL and testbench

- Sequencing controller for the SHA-256 compression datapath.
- Accepts 512-bit message blocks through a valid/ready handshake, without handling the block data itself.
- Issues all datapath control strobes: H initialisation, message-schedule load, the 64 round enables with the k_lut address, and the final H accumulate.
- Presents the finished digest with a valid/ready handshake.

---
 rtl/sha256_round_ctrl_if.sv | 31 +++
 rtl/sha256_round_ctrl.sv | 156 +++++++++++++++
 tb/tb_sha256_round_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// sha256_round_ctrl_if
//   Handshake bundle of the SHA-256 round controller.
//   blk_valid    : upstream has a padded 512-bit block ready
//   blk_first    : qualifies blk_valid, first block of a message
//   blk_last     : qualifies blk_valid, last block of a message
//   blk_ready    : controller can accept a block
//   digest_valid : H holds the final digest
//   digest_ready : consumer takes the digest
//   Modports:
//     master : block producer / digest consumer side
//     slave  : controller side
// ---------------------------------------------------------------------------
interface sha256_round_ctrl_if;
   logic blk_valid;
   logic blk_first;
   logic blk_last;
   logic blk_ready;
   logic digest_valid;
   logic digest_ready;

   modport master (
      output blk_valid, blk_first, blk_last, digest_ready,
      input  blk_ready, digest_valid
   );

   modport slave (
      input  blk_valid, blk_first, blk_last, digest_ready,
      output blk_ready, digest_valid
   );
endinterface

// File: rtl/sha256_round_ctrl.sv
// ---------------------------------------------------------------------------
// sha256_round_ctrl
//   Sequencing controller for the SHA-256 compression datapath. It never
//   touches block or digest data; it only issues the datapath strobes.
//   Per block: LOAD (1 cycle), ROUND (ROUNDS cycles), ADD (1 cycle), then
//   either back to IDLE (more blocks follow) or DONE (digest offered).
//
//   Ports:
//     CLK        : clock, rising edge
//     nreset     : asynchronous active-low reset
//     bus        : block intake and digest handshakes (slave modport)
//     init_h     : datapath loads H0..H7 (and a..h) from the IVs
//     load_w     : datapath latches the block into W, loads a..h
//     round_en   : datapath executes one compression round
//     round_idx  : current round, k_lut address; 0 outside ROUND
//     w_from_msg : round uses the message word (round_idx < 16)
//     add_en     : datapath performs H[i] += working var
//     err_seq    : one-cycle pulse, continuation block with no open message
//     busy       : controller is not in IDLE
//   All outputs are registers or decode registers only; no input reaches an
//   output combinationally.
// ---------------------------------------------------------------------------
module sha256_round_ctrl #(
   parameter int ROUNDS = 64,
   parameter int IDX_W  = 6
) (
   input  logic               CLK,
   input  logic               nreset,
   sha256_round_ctrl_if.slave bus,
   output logic               init_h,
   output logic               load_w,
   output logic               round_en,
   output logic [IDX_W-1:0]   round_idx,
   output logic               w_from_msg,
   output logic               add_en,
   output logic               err_seq,
   output logic               busy
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ROUND,
      ADD,
      DONE
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ROUNDS - 1);
   localparam int               MSG_WORDS = 16;

   state_t state;
   logic   msg_open;   // a message has started and its last block is not yet added
   logic   first_q;    // accepted block starts a message: H comes from the IVs
   logic   last_q;     // accepted block ends its message: digest follows ADD

   // load_w is high only during LOAD, so this is init_h = (state==LOAD) & first_q.
   assign init_h = load_w & first_q;

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every branch below sees the values from before this clock edge.
   always_ff @(posedge CLK or negedge nreset) begin
      if (!nreset) begin
         state            <= IDLE;
         round_idx        <= '0;
         msg_open         <= 1'b0;
         first_q          <= 1'b0;
         last_q           <= 1'b0;
         bus.blk_ready    <= 1'b1;
         bus.digest_valid <= 1'b0;
         load_w           <= 1'b0;
         round_en         <= 1'b0;
         w_from_msg       <= 1'b0;
         add_en           <= 1'b0;
         err_seq          <= 1'b0;
         busy             <= 1'b0;
      end else begin
         // NOTE: single-cycle strobes get a default clear every edge; only the
         // state that wants them high for the next cycle sets them again.
         load_w  <= 1'b0;
         add_en  <= 1'b0;
         err_seq <= 1'b0;

         case (state)
            IDLE: begin
               if (bus.blk_valid) begin
                  // A continuation block with no open message is treated as
                  // a first block and flagged; a first block while a message
                  // is open simply restarts it.
                  first_q       <= bus.blk_first | ~msg_open;
                  last_q        <= bus.blk_last;
                  err_seq       <= ~bus.blk_first & ~msg_open;
                  load_w        <= 1'b1;
                  bus.blk_ready <= 1'b0;
                  busy          <= 1'b1;
                  state         <= LOAD;
               end
            end

            LOAD: begin
               msg_open   <= 1'b1;
               round_idx  <= '0;
               round_en   <= 1'b1;
               w_from_msg <= 1'b1;     // round 0 always takes a message word
               state      <= ROUND;
            end

            ROUND: begin
               if (round_idx == LAST_IDX) begin
                  round_idx  <= '0;
                  round_en   <= 1'b0;
                  w_from_msg <= 1'b0;
                  add_en     <= 1'b1;
                  state      <= ADD;
               end else begin
                  round_idx  <= round_idx + 1'b1;
                  // Registered one cycle early: flag for the round about to run.
                  w_from_msg <= (int'(round_idx) + 1) < MSG_WORDS;
               end
            end

            ADD: begin
               if (last_q) begin
                  msg_open         <= 1'b0;
                  bus.digest_valid <= 1'b1;
                  state            <= DONE;
               end else begin
                  bus.blk_ready <= 1'b1;
                  busy          <= 1'b0;
                  state         <= IDLE;
               end
            end

            DONE: begin
               if (bus.digest_ready) begin
                  bus.digest_valid <= 1'b0;
                  bus.blk_ready    <= 1'b1;
                  busy             <= 1'b0;
                  state            <= IDLE;
               end
            end

            default: begin
               // Unreachable encodings fall back to a clean IDLE.
               round_idx        <= '0;
               round_en         <= 1'b0;
               w_from_msg       <= 1'b0;
               bus.digest_valid <= 1'b0;
               bus.blk_ready    <= 1'b1;
               busy             <= 1'b0;
               state            <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sha256_round_ctrl
//   Self-checking bench for sha256_round_ctrl. The expected output vector for
//   every cycle is derived from the cycle count since block acceptance and
//   from a one-bit model of whether a message is open. Outputs are sampled on
//   the falling edge; inputs are driven there too.
// ---------------------------------------------------------------------------
module tb_sha256_round_ctrl;

   localparam int          ROUNDS = 64;
   localparam int          IDX_W  = 6;
   localparam int          K_ADD  = ROUNDS + 2;   // ADD cycle after acceptance
   localparam int          K_END  = ROUNDS + 3;   // first cycle after ADD
   localparam logic [14:0] IDLE_V = 15'h4000;     // only blk_ready high

   logic             CLK = 1'b0;
   logic             nreset;
   logic             init_h, load_w, round_en, w_from_msg, add_en, err_seq, busy;
   logic [IDX_W-1:0] round_idx;

   int n_cmp = 0;
   int n_bad = 0;
   bit m_open;          // reference model: a message is open

   sha256_round_ctrl_if bus ();

   sha256_round_ctrl #(.ROUNDS(ROUNDS), .IDX_W(IDX_W)) dut (
      .CLK        (CLK),
      .nreset     (nreset),
      .bus        (bus),
      .init_h     (init_h),
      .load_w     (load_w),
      .round_en   (round_en),
      .round_idx  (round_idx),
      .w_from_msg (w_from_msg),
      .add_en     (add_en),
      .err_seq    (err_seq),
      .busy       (busy)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // {blk_ready, init_h, load_w, round_en, round_idx, w_from_msg, add_en, digest_valid, err_seq, busy}
   function automatic logic [14:0] observed();
      return {bus.blk_ready, init_h, load_w, round_en, round_idx,
              w_from_msg, add_en, bus.digest_valid, err_seq, busy};
   endfunction

   // Expected outputs k cycles after a block was accepted (k >= 1).
   function automatic logic [14:0] exp_vec(int k, bit ini, bit err, bit last);
      logic             rdy, ih, lw, re, wm, ad, dv, es, bz;
      logic [IDX_W-1:0] ix;
      {rdy, ih, lw, re, wm, ad, dv, es} = '0;
      bz = 1'b1;
      ix = '0;
      if (k == 1) begin
         ih = ini; lw = 1'b1; es = err;
      end else if (k <= ROUNDS + 1) begin
         re = 1'b1; ix = IDX_W'(k - 2); wm = (k - 2) < 16;
      end else if (k == K_ADD) begin
         ad = 1'b1;
      end else if (last) begin
         dv = 1'b1;
      end else begin
         rdy = 1'b1; bz = 1'b0;
      end
      return {rdy, ih, lw, re, ix, wm, ad, dv, es, bz};
   endfunction

   task automatic drive(input int v, input int f, input int l, input int r);
      bus.blk_valid    = 1'(v);
      bus.blk_first    = 1'(f);
      bus.blk_last     = 1'(l);
      bus.digest_ready = 1'(r);
   endtask

   // Model of block acceptance: IV load and sequencing error from message state.
   task automatic model_accept(input int f, input int l, output bit ini, output bit err);
      ini    = (f != 0) || !m_open;
      err    = (f == 0) && !m_open;
      m_open = (l == 0);
   endtask

   task automatic test_reset();
      nreset = 1'b0;
      drive(1, 1, 1, 1);
      m_open = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         n_cmp++;
         if (observed() !== IDLE_V) begin
            n_bad++; $display("FAIL reset_hold got=%h exp=%h", observed(), IDLE_V);
         end
      end
      drive(0, 0, 0, 0);
      nreset = 1'b1;
      @(negedge CLK);
      n_cmp++;
      if (observed() !== IDLE_V) begin
         n_bad++; $display("FAIL reset_release got=%h exp=%h", observed(), IDLE_V);
      end
   endtask

   task automatic test_single_block();
      bit ini, err;
      drive(1, 1, 1, 0);
      model_accept(1, 1, ini, err);
      @(posedge CLK);
      for (int k = 1; k <= K_END; k++) begin
         @(negedge CLK);
         if (k == 1) drive(0, 0, 0, 0);
         n_cmp++;
         if (observed() !== exp_vec(k, ini, err, 1'b1)) begin
            n_bad++; $display("FAIL single k=%0d got=%h exp=%h", k, observed(), exp_vec(k, ini, err, 1'b1));
         end
      end
      drive(0, 0, 0, 1);
      @(negedge CLK);
      drive(0, 0, 0, 0);
      n_cmp++;
      if (observed() !== IDLE_V) begin
         n_bad++; $display("FAIL single_release got=%h exp=%h", observed(), IDLE_V);
      end
   endtask

   task automatic test_two_block();
      bit ini_a, err_a, ini_b, err_b;
      drive(1, 1, 0, 0);
      model_accept(1, 0, ini_a, err_a);
      @(posedge CLK);
      for (int k = 1; k <= K_END; k++) begin
         @(negedge CLK);
         if (k == 1) drive(1, 0, 1, 0);   // block B offered and held
         n_cmp++;
         if (observed() !== exp_vec(k, ini_a, err_a, 1'b0)) begin
            n_bad++; $display("FAIL two_blk_a k=%0d got=%h exp=%h", k, observed(), exp_vec(k, ini_a, err_a, 1'b0));
         end
      end
      model_accept(0, 1, ini_b, err_b);   // accepted on the edge ending cycle 67
      for (int k = 1; k <= K_END; k++) begin
         @(negedge CLK);
         if (k == 1) drive(0, 0, 0, 0);
         n_cmp++;
         if (observed() !== exp_vec(k, ini_b, err_b, 1'b1)) begin
            n_bad++; $display("FAIL two_blk_b k=%0d got=%h exp=%h", k, observed(), exp_vec(k, ini_b, err_b, 1'b1));
         end
      end
      drive(0, 0, 0, 1);
      @(negedge CLK);
      drive(0, 0, 0, 0);
      n_cmp++;
      if (observed() !== IDLE_V) begin
         n_bad++; $display("FAIL two_blk_release got=%h exp=%h", observed(), IDLE_V);
      end
   endtask

   task automatic test_backpressure();
      bit ini, err;
      drive(1, 1, 1, 0);                   // blk_valid stays high throughout
      model_accept(1, 1, ini, err);
      @(posedge CLK);
      for (int k = 1; k <= K_END + 10; k++) begin
         @(negedge CLK);
         n_cmp++;
         if (observed() !== exp_vec(k, ini, err, 1'b1)) begin
            n_bad++; $display("FAIL backpressure k=%0d got=%h exp=%h", k, observed(), exp_vec(k, ini, err, 1'b1));
         end
      end
      drive(1, 1, 1, 1);
      @(negedge CLK);
      drive(0, 0, 0, 0);
      n_cmp++;
      if (observed() !== IDLE_V) begin
         n_bad++; $display("FAIL backpressure_release got=%h exp=%h", observed(), IDLE_V);
      end
   endtask

   task automatic test_seq_error();
      bit ini, err;
      nreset = 1'b0;
      @(negedge CLK);
      nreset = 1'b1;
      m_open = 1'b0;
      drive(1, 0, 1, 0);
      model_accept(0, 1, ini, err);
      @(posedge CLK);
      for (int k = 1; k <= K_END; k++) begin
         @(negedge CLK);
         if (k == 1) drive(0, 0, 0, 0);
         n_cmp++;
         if (observed() !== exp_vec(k, ini, err, 1'b1)) begin
            n_bad++; $display("FAIL seq_error k=%0d got=%h exp=%h", k, observed(), exp_vec(k, ini, err, 1'b1));
         end
      end
      drive(0, 0, 0, 1);
      @(negedge CLK);
      drive(0, 0, 0, 0);
      n_cmp++;
      if (observed() !== IDLE_V) begin
         n_bad++; $display("FAIL seq_error_release got=%h exp=%h", observed(), IDLE_V);
      end
   endtask

   task automatic test_async_reset();
      bit ini, err;
      drive(1, 1, 1, 0);
      model_accept(1, 1, ini, err);
      @(posedge CLK);
      for (int k = 1; k <= 32; k++) begin   // k=32 is round_idx 30
         @(negedge CLK);
         n_cmp++;
         if (observed() !== exp_vec(k, ini, err, 1'b1)) begin
            n_bad++; $display("FAIL async_pre k=%0d got=%h exp=%h", k, observed(), exp_vec(k, ini, err, 1'b1));
         end
      end
      #2 nreset = 1'b0;
      drive(0, 0, 0, 0);
      m_open = 1'b0;
      #1;
      n_cmp++;
      if (observed() !== IDLE_V) begin
         n_bad++; $display("FAIL async_immediate got=%h exp=%h", observed(), IDLE_V);
      end
      @(negedge CLK);
      nreset = 1'b1;
      for (int c = 0; c < ROUNDS + 5; c++) begin
         @(negedge CLK);
         n_cmp++;
         if (observed() !== IDLE_V) begin
            n_bad++; $display("FAIL async_after c=%0d got=%h exp=%h", c, observed(), IDLE_V);
         end
      end
      drive(1, 1, 1, 0);
      model_accept(1, 1, ini, err);
      @(posedge CLK);
      for (int k = 1; k <= 6; k++) begin
         @(negedge CLK);
         if (k == 1) drive(0, 0, 0, 0);
         n_cmp++;
         if (observed() !== exp_vec(k, ini, err, 1'b1)) begin
            n_bad++; $display("FAIL async_restart k=%0d got=%h exp=%h", k, observed(), exp_vec(k, ini, err, 1'b1));
         end
      end
      nreset = 1'b0;
      m_open = 1'b0;
      @(negedge CLK);
      nreset = 1'b1;
   endtask

   task automatic test_restart();
      bit ini_a, err_a, ini_b, err_b;
      drive(1, 1, 0, 0);
      model_accept(1, 0, ini_a, err_a);
      @(posedge CLK);
      for (int k = 1; k <= K_END; k++) begin
         @(negedge CLK);
         if (k == 1) drive(0, 0, 0, 0);
         n_cmp++;
         if (observed() !== exp_vec(k, ini_a, err_a, 1'b0)) begin
            n_bad++; $display("FAIL restart_a k=%0d got=%h exp=%h", k, observed(), exp_vec(k, ini_a, err_a, 1'b0));
         end
      end
      drive(1, 1, 1, 0);                   // new first block while message open
      model_accept(1, 1, ini_b, err_b);
      @(posedge CLK);
      for (int k = 1; k <= K_END; k++) begin
         @(negedge CLK);
         if (k == 1) drive(0, 0, 0, 0);
         n_cmp++;
         if (observed() !== exp_vec(k, ini_b, err_b, 1'b1)) begin
            n_bad++; $display("FAIL restart_b k=%0d got=%h exp=%h", k, observed(), exp_vec(k, ini_b, err_b, 1'b1));
         end
      end
      drive(0, 0, 0, 1);
      @(negedge CLK);
      drive(0, 0, 0, 0);
      n_cmp++;
      if (observed() !== IDLE_V) begin
         n_bad++; $display("FAIL restart_release got=%h exp=%h", observed(), IDLE_V);
      end
   endtask

   task automatic test_random();
      bit ini, err;
      int f, l, gap, hold;
      for (int b = 0; b < 20; b++) begin
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            drive(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            @(negedge CLK);
            n_cmp++;
            if (observed() !== IDLE_V) begin
               n_bad++; $display("FAIL random_idle b=%0d got=%h exp=%h", b, observed(), IDLE_V);
            end
         end
         f = $urandom_range(0, 1);
         l = $urandom_range(0, 1);
         drive(1, f, l, $urandom_range(0, 1));
         model_accept(f, l, ini, err);
         for (int k = 1; k <= K_END; k++) begin
            @(negedge CLK);
            n_cmp++;
            if (observed() !== exp_vec(k, ini, err, l != 0)) begin
               n_bad++; $display("FAIL random b=%0d k=%0d got=%h exp=%h", b, k, observed(), exp_vec(k, ini, err, l != 0));
            end
            if (k < K_END) drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            else           drive(0, 0, 0, 0);
         end
         if (l != 0) begin
            hold = $urandom_range(0, 4);
            for (int h = 0; h < hold; h++) begin
               drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 0);
               @(negedge CLK);
               n_cmp++;
               if (observed() !== exp_vec(K_END, ini, err, 1'b1)) begin
                  n_bad++; $display("FAIL random_hold b=%0d got=%h exp=%h", b, observed(), exp_vec(K_END, ini, err, 1'b1));
               end
            end
            drive(0, 0, 0, 1);
            @(negedge CLK);
            drive(0, 0, 0, 0);
            n_cmp++;
            if (observed() !== IDLE_V) begin
               n_bad++; $display("FAIL random_release b=%0d got=%h exp=%h", b, observed(), IDLE_V);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_block();
      test_two_block();
      test_backpressure();
      test_seq_error();
      test_async_reset();
      test_restart();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
